// File: rtl/imem_loader.sv
// imem_loader: packs a UART byte stream MSB-first into instruction words and
// writes them to consecutive instruction-memory addresses starting at 0.
// The load ends on the halt word or after the last address has been written.
module imem_loader #(
    parameter int unsigned                NB_DATA    = 32,
    parameter int unsigned                NB_BYTE    = 8,
    parameter int unsigned                NB_ADDRESS = 4,
    parameter logic [NB_DATA-1:0]         HALT_WORD  = 32'hFFFF_FFFF
) (
    input  logic                    i_clk,
    input  logic                    i_reset,
    input  logic                    i_start,
    input  logic [NB_BYTE-1:0]      i_rx_data,
    input  logic                    i_rx_valid,
    output logic [NB_ADDRESS-1:0]   o_w_addr,
    output logic [NB_DATA-1:0]      o_w_data,
    output logic                    o_w_en,
    output logic                    o_busy,
    output logic                    o_done,
    output logic                    o_full,
    output logic [NB_ADDRESS:0]     o_word_count
);

    localparam int unsigned NB_CNT = 2;
    localparam int unsigned NB_WC  = NB_ADDRESS + 1;
    localparam logic [NB_ADDRESS-1:0] ADDR_LAST = {NB_ADDRESS{1'b1}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RECV = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                  state, state_nxt;
    logic [NB_CNT-1:0]       byte_cnt, byte_cnt_nxt;
    logic [NB_DATA-1:0]      asm_word, asm_word_nxt;
    logic [NB_ADDRESS-1:0]   addr, addr_nxt;
    logic [NB_WC-1:0]        word_count_nxt;
    logic                    full_nxt;
    logic                    w_en_nxt;
    logic [NB_ADDRESS-1:0]   w_addr_nxt;
    logic [NB_DATA-1:0]      w_data_nxt;
    logic [NB_DATA-1:0]      word_c;

    // State and datapath registers; every output is taken straight from a flop
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state        <= IDLE;
            byte_cnt     <= '0;
            asm_word     <= '0;
            addr         <= '0;
            o_word_count <= '0;
            o_full       <= 1'b0;
            o_w_en       <= 1'b0;
            o_w_addr     <= '0;
            o_w_data     <= '0;
            o_busy       <= 1'b0;
            o_done       <= 1'b0;
        end else begin
            state        <= state_nxt;
            byte_cnt     <= byte_cnt_nxt;
            asm_word     <= asm_word_nxt;
            addr         <= addr_nxt;
            o_word_count <= word_count_nxt;
            o_full       <= full_nxt;
            o_w_en       <= w_en_nxt;
            o_w_addr     <= w_addr_nxt;
            o_w_data     <= w_data_nxt;
            o_busy       <= (state_nxt == RECV);
            o_done       <= (state_nxt == DONE);
        end
    end

    // Next-state, byte assembly and write-port generation
    always_comb begin
        state_nxt      = state;
        byte_cnt_nxt   = byte_cnt;
        asm_word_nxt   = asm_word;
        addr_nxt       = addr;
        word_count_nxt = o_word_count;
        full_nxt       = o_full;
        w_en_nxt       = 1'b0;
        w_addr_nxt     = o_w_addr;
        w_data_nxt     = o_w_data;
        word_c         = {asm_word[NB_DATA-NB_BYTE-1:0], i_rx_data};

        case (state)
            IDLE, DONE: begin
                if (i_start) begin
                    state_nxt      = RECV;
                    byte_cnt_nxt   = '0;
                    asm_word_nxt   = '0;
                    addr_nxt       = '0;
                    word_count_nxt = '0;
                    full_nxt       = 1'b0;
                end
            end
            RECV: begin
                if (i_start) begin
                    // restart drops the partial word and any byte in this cycle
                    byte_cnt_nxt   = '0;
                    asm_word_nxt   = '0;
                    addr_nxt       = '0;
                    word_count_nxt = '0;
                    full_nxt       = 1'b0;
                end else if (i_rx_valid) begin
                    asm_word_nxt = word_c;
                    byte_cnt_nxt = byte_cnt + NB_CNT'(1);
                    if (byte_cnt == {NB_CNT{1'b1}}) begin
                        w_en_nxt       = 1'b1;
                        w_addr_nxt     = addr;
                        w_data_nxt     = word_c;
                        addr_nxt       = addr + NB_ADDRESS'(1);
                        word_count_nxt = o_word_count + NB_WC'(1);
                        if (word_c == HALT_WORD) begin
                            state_nxt = DONE;
                        end else if (addr == ADDR_LAST) begin
                            state_nxt = DONE;
                            full_nxt  = 1'b1;
                        end
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_imem_loader.sv
// Directed self-checking bench for imem_loader with a behavioural memory model.
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic [3:0]  w_addr;
    logic [31:0] w_data;
    logic        w_en;
    logic        busy;
    logic        done;
    logic        full;
    logic [4:0]  word_count;

    int n_cmp = 0;
    int n_err = 0;
    int wr_cnt = 0;
    int wr_base;
    logic [31:0] mem [16];

    imem_loader dut (
        .i_clk        (clk),
        .i_reset      (rst),
        .i_start      (start),
        .i_rx_data    (rx_data),
        .i_rx_valid   (rx_valid),
        .o_w_addr     (w_addr),
        .o_w_data     (w_data),
        .o_w_en       (w_en),
        .o_busy       (busy),
        .o_done       (done),
        .o_full       (full),
        .o_word_count (word_count)
    );

    always #5 clk = ~clk;

    // Instruction memory model fed by the write port
    always @(posedge clk) begin
        if (w_en) begin
            mem[w_addr] <= w_data;
            wr_cnt      <= wr_cnt + 1;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Send one word MSB first, 'gap' idle cycles between bytes, then check the write
    task automatic send_word(input logic [31:0] w, input int gap, input logic [3:0] a,
                             input logic exp_done, input logic exp_full, input string tag);
        for (int i = 0; i < 4; i++) begin
            rx_data  = w[31-8*i -: 8];
            rx_valid = 1'b1;
            @(negedge clk);
            rx_valid = 1'b0;
            if (i < 3) begin
                chk({tag, "_noen"}, 64'(w_en), 64'(0));
                repeat (gap) @(negedge clk);
            end
        end
        chk({tag, "_en"},   64'(w_en),   64'(1));
        chk({tag, "_addr"}, 64'(w_addr), 64'(a));
        chk({tag, "_data"}, 64'(w_data), 64'(w));
        chk({tag, "_done"}, 64'(done),   64'(exp_done));
        chk({tag, "_full"}, 64'(full),   64'(exp_full));
        chk({tag, "_busy"}, 64'(busy),   64'(!exp_done));
    endtask

    initial begin
        // Reset with a byte strobe active
        rst = 1'b1; start = 1'b0; rx_data = 8'h55; rx_valid = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_en",    64'(w_en),       64'(0));
        chk("rst_addr",  64'(w_addr),     64'(0));
        chk("rst_data",  64'(w_data),     64'(0));
        chk("rst_busy",  64'(busy),       64'(0));
        chk("rst_done",  64'(done),       64'(0));
        chk("rst_full",  64'(full),       64'(0));
        chk("rst_wc",    64'(word_count), 64'(0));
        rst = 1'b0;
        @(negedge clk);
        rx_valid = 1'b0;
        chk("idle_ignore_busy", 64'(busy), 64'(0));
        chk("idle_ignore_wr",   64'(wr_cnt), 64'(0));

        // Normal load with idle gaps between bytes, ending on the halt word
        pulse_start();
        chk("start_busy", 64'(busy), 64'(1));
        send_word(32'h8C01_0004, 1, 4'd0, 1'b0, 1'b0, "n0");
        @(negedge clk);
        chk("n0_pulse", 64'(w_en), 64'(0));
        send_word(32'h2002_0005, 2, 4'd1, 1'b0, 1'b0, "n1");
        @(negedge clk);
        chk("n1_pulse", 64'(w_en), 64'(0));
        send_word(32'hFFFF_FFFF, 0, 4'd2, 1'b1, 1'b0, "n2");
        chk("n_wc", 64'(word_count), 64'(3));
        @(negedge clk);
        chk("n2_pulse", 64'(w_en), 64'(0));
        chk("n_mem0", 64'(mem[0]), 64'h8C01_0004);
        chk("n_mem1", 64'(mem[1]), 64'h2002_0005);
        chk("n_mem2", 64'(mem[2]), 64'hFFFF_FFFF);
        chk("n_wrcnt", 64'(wr_cnt), 64'(3));

        // Bytes in DONE are ignored and the last write is held
        for (int i = 0; i < 8; i++) begin
            rx_data = 8'(i); rx_valid = 1'b1;
            @(negedge clk);
        end
        rx_valid = 1'b0;
        chk("done_ign_wr",   64'(wr_cnt), 64'(3));
        chk("done_ign_done", 64'(done),   64'(1));
        chk("done_hold_addr",64'(w_addr), 64'(2));
        chk("done_hold_data",64'(w_data), 64'hFFFF_FFFF);

        // Full memory: 16 back-to-back words, no halt word
        wr_base = wr_cnt;
        pulse_start();
        chk("f_done_clr", 64'(done), 64'(0));
        chk("f_wc_clr",   64'(word_count), 64'(0));
        for (int k = 0; k < 16; k++)
            send_word(32'(k), 0, 4'(k), k == 15, k == 15, "full");
        chk("f_wc", 64'(word_count), 64'(16));
        for (int i = 0; i < 8; i++) begin
            rx_data = 8'hA5; rx_valid = 1'b1;
            @(negedge clk);
        end
        rx_valid = 1'b0;
        chk("f_wrcnt", 64'(wr_cnt - wr_base), 64'(16));
        chk("f_full_sticky", 64'(full), 64'(1));
        chk("f_mem7",  64'(mem[7]),  64'(7));
        chk("f_mem15", 64'(mem[15]), 64'(15));

        // Halt word on the last address: halt wins, full stays low
        pulse_start();
        chk("h_full_clr", 64'(full), 64'(0));
        for (int k = 0; k < 15; k++)
            send_word(32'(k + 100), 0, 4'(k), 1'b0, 1'b0, "hl");
        send_word(32'hFFFF_FFFF, 0, 4'd15, 1'b1, 1'b0, "hl_last");
        chk("hl_wc", 64'(word_count), 64'(16));

        // Restart mid-word; the byte in the restart cycle is dropped
        pulse_start();
        rx_data = 8'hDE; rx_valid = 1'b1; @(negedge clk);
        rx_data = 8'hAD; rx_valid = 1'b1; @(negedge clk);
        rx_data = 8'h99; start = 1'b1;    @(negedge clk);
        start = 1'b0; rx_valid = 1'b0;
        wr_base = wr_cnt;
        send_word(32'h1122_3344, 0, 4'd0, 1'b0, 1'b0, "rs");
        chk("rs_wc", 64'(word_count), 64'(1));
        @(negedge clk);
        chk("rs_wrcnt", 64'(wr_cnt - wr_base), 64'(1));
        chk("rs_mem0",  64'(mem[0]), 64'h1122_3344);

        // Reset mid-word; no write for the partial word
        for (int i = 0; i < 3; i++) begin
            rx_data = 8'(8'h30 + i); rx_valid = 1'b1;
            @(negedge clk);
        end
        rx_valid = 1'b0;
        wr_base = wr_cnt;
        rst = 1'b1; start = 1'b1;
        @(negedge clk);
        rst = 1'b0; start = 1'b0;
        chk("rm_en",   64'(w_en),       64'(0));
        chk("rm_busy", 64'(busy),       64'(0));
        chk("rm_wc",   64'(word_count), 64'(0));
        chk("rm_data", 64'(w_data),     64'(0));
        pulse_start();
        send_word(32'hAABB_CCDD, 1, 4'd0, 1'b0, 1'b0, "rm");
        @(negedge clk);
        chk("rm_wrcnt", 64'(wr_cnt - wr_base), 64'(1));
        chk("rm_mem0",  64'(mem[0]), 64'hAABB_CCDD);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
